muldiv_ctrl: RTL and testbench

Multi-cycle multiply/divide sequencer for the Gemini core's EX stage. It accepts MULT/MULTU/DIV/DIVU from EX, stalls EX while the operation runs, and presents a 64-bit {HI,LO} result for exactly one cycle. EX carries that result down the pipe as its full HILO write (2'b11), and the HILO register and its bypass consume it. Flushes from the exception unit cancel any operation in flight.

---
 rtl/gemini_pkg.sv | 36 +++
 rtl/div_iter_u32.sv | 77 +++++++
 rtl/muldiv_ctrl.sv | 169 ++++++++++++++++
 tb/tb_muldiv_ctrl.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/gemini_pkg.sv
// Shared multiply/divide encodings, FSM states and arithmetic helpers for the Gemini EX stage.
package gemini_pkg;

    localparam int unsigned XLEN = 32;

    typedef enum logic [2:0] {
        MD_NONE  = 3'b000,
        MD_MULT  = 3'b001,
        MD_MULTU = 3'b010,
        MD_DIV   = 3'b011,
        MD_DIVU  = 3'b100
    } md_op_e;

    // State names carry ST_ so they stay distinct from the MD_DIV opcode.
    typedef enum logic [1:0] {
        MD_ST_IDLE = 2'b00,
        MD_ST_MUL  = 2'b01,
        MD_ST_DIV  = 2'b10,
        MD_ST_DONE = 2'b11
    } md_state_e;

    function automatic logic [2*XLEN-1:0] md_mul64(input logic sgn,
                                                   input logic [XLEN-1:0] a,
                                                   input logic [XLEN-1:0] b);
        logic [2*XLEN-1:0] ea;
        logic [2*XLEN-1:0] eb;
        ea = sgn ? {{XLEN{a[XLEN-1]}}, a} : {{XLEN{1'b0}}, a};
        eb = sgn ? {{XLEN{b[XLEN-1]}}, b} : {{XLEN{1'b0}}, b};
        return ea * eb;
    endfunction

    function automatic logic [XLEN-1:0] md_abs(input logic sgn, input logic [XLEN-1:0] x);
        return (sgn && x[XLEN-1]) ? (~x + XLEN'(1)) : x;
    endfunction

endpackage

// File: rtl/div_iter_u32.sv
// Unsigned radix-2 restoring divider; the first iteration happens on the start edge, 32 in total.
module div_iter_u32
    import gemini_pkg::*;
(
    input  logic            clk,
    input  logic            resetn,
    input  logic            start,
    input  logic [XLEN-1:0] dividend,
    input  logic [XLEN-1:0] divisor,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] quotient,
    output logic [XLEN-1:0] remainder
);

    localparam int unsigned CNT_W = 5;

    logic [XLEN-1:0]  r_rem;
    logic [XLEN-1:0]  r_quo;
    logic [XLEN-1:0]  r_div;
    logic [CNT_W-1:0] r_cnt;
    logic             r_busy;
    logic             r_done;

    logic [XLEN-1:0]  w_rem_src;
    logic [XLEN-1:0]  w_quo_src;
    logic [XLEN-1:0]  w_div_src;
    logic [XLEN:0]    w_shift;
    logic [XLEN:0]    w_diff;
    logic             w_ge;
    logic [XLEN-1:0]  w_rem_next;
    logic [XLEN-1:0]  w_quo_next;

    // One restoring step, fed from the fresh operands on start so no cycle is lost.
    assign w_rem_src  = start ? '0       : r_rem;
    assign w_quo_src  = start ? dividend : r_quo;
    assign w_div_src  = start ? divisor  : r_div;
    assign w_shift    = {w_rem_src, w_quo_src[XLEN-1]};
    assign w_diff     = w_shift - {1'b0, w_div_src};
    assign w_ge       = ~w_diff[XLEN];
    assign w_rem_next = w_ge ? w_diff[XLEN-1:0] : w_shift[XLEN-1:0];
    assign w_quo_next = {w_quo_src[XLEN-2:0], w_ge};

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_rem  <= '0;
            r_quo  <= '0;
            r_div  <= '0;
            r_cnt  <= '0;
            r_busy <= 1'b0;
            r_done <= 1'b0;
        end else if (start) begin
            r_rem  <= w_rem_next;
            r_quo  <= w_quo_next;
            r_div  <= divisor;
            r_cnt  <= CNT_W'(1);
            r_busy <= 1'b1;
            r_done <= 1'b0;
        end else if (r_busy) begin
            r_rem  <= w_rem_next;
            r_quo  <= w_quo_next;
            r_cnt  <= r_cnt + CNT_W'(1);
            if (r_cnt == {CNT_W{1'b1}}) begin
                r_busy <= 1'b0;
                r_done <= 1'b1;
            end
        end else begin
            r_done <= 1'b0;
        end
    end

    assign busy      = r_busy;
    assign done      = r_done;
    assign quotient  = r_quo;
    assign remainder = r_rem;

endmodule

// File: rtl/muldiv_ctrl.sv
// EX-stage multiply/divide sequencer: stalls EX while running and pulses a registered {HI,LO} result.
module muldiv_ctrl
    import gemini_pkg::*;
#(
    parameter int unsigned MUL_LAT = 2
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic                ex_valid,
    input  logic [2:0]          ex_op,
    input  logic [XLEN-1:0]     ex_src_a,
    input  logic [XLEN-1:0]     ex_src_b,
    input  logic                flush,
    output logic                stall_ex,
    output logic [2*XLEN-1:0]   result,
    output logic                result_valid
);

    localparam int unsigned MCNT_W   = 2;
    localparam logic [MCNT_W-1:0] MUL_LAST = MCNT_W'(MUL_LAT - 2);

    md_state_e         r_state;
    md_state_e         w_state_next;
    logic [2:0]        r_op;
    logic [XLEN-1:0]   r_a;
    logic [XLEN-1:0]   r_b;
    logic [MCNT_W-1:0] r_mcnt;
    logic [2*XLEN-1:0] r_result;
    logic              r_result_valid;

    logic              w_ex_legal;
    logic              w_ex_is_mul;
    logic              w_accept;
    logic              w_div_start;
    logic              w_load_result;
    logic [2*XLEN-1:0] w_result_next;

    logic              w_in_idle;
    logic [XLEN-1:0]   w_mul_a;
    logic [XLEN-1:0]   w_mul_b;
    logic              w_mul_sgn;
    logic [2*XLEN-1:0] w_mul_prod;

    logic              w_div_busy;
    logic              w_div_done;
    logic [XLEN-1:0]   w_div_quo;
    logic [XLEN-1:0]   w_div_rem;
    logic              w_div_sgn;
    logic [XLEN-1:0]   w_quo_fix;
    logic [XLEN-1:0]   w_rem_fix;
    logic [2*XLEN-1:0] w_div_res;

    assign w_ex_legal  = ex_valid && (ex_op inside {MD_MULT, MD_MULTU, MD_DIV, MD_DIVU});
    assign w_ex_is_mul = (ex_op == MD_MULT) || (ex_op == MD_MULTU);

    // A single multiplier serves both the single-cycle path (live operands) and the latched path.
    assign w_in_idle  = (r_state == MD_ST_IDLE);
    assign w_mul_a    = w_in_idle ? ex_src_a : r_a;
    assign w_mul_b    = w_in_idle ? ex_src_b : r_b;
    assign w_mul_sgn  = w_in_idle ? (ex_op == MD_MULT) : (r_op == MD_MULT);
    assign w_mul_prod = md_mul64(w_mul_sgn, w_mul_a, w_mul_b);

    div_iter_u32 u_div (
        .clk       (clk),
        .resetn    (resetn),
        .start     (w_div_start),
        .dividend  (md_abs(ex_op == MD_DIV, ex_src_a)),
        .divisor   (md_abs(ex_op == MD_DIV, ex_src_b)),
        .busy      (w_div_busy),
        .done      (w_div_done),
        .quotient  (w_div_quo),
        .remainder (w_div_rem)
    );

    // Signed fixup; divide-by-zero bypasses it and returns the raw dividend in HI.
    assign w_div_sgn = (r_op == MD_DIV);
    assign w_quo_fix = (w_div_sgn && (r_a[XLEN-1] ^ r_b[XLEN-1])) ? (~w_div_quo + XLEN'(1)) : w_div_quo;
    assign w_rem_fix = (w_div_sgn && r_a[XLEN-1]) ? (~w_div_rem + XLEN'(1)) : w_div_rem;
    assign w_div_res = (r_b == '0) ? {r_a, {XLEN{1'b1}}} : {w_rem_fix, w_quo_fix};

    always_comb begin
        w_state_next  = r_state;
        w_accept      = 1'b0;
        w_div_start   = 1'b0;
        w_load_result = 1'b0;
        w_result_next = r_result;
        stall_ex      = 1'b0;
        case (r_state)
            MD_ST_IDLE: begin
                if (w_ex_legal && !flush) begin
                    w_accept = 1'b1;
                    stall_ex = 1'b1;
                    if (w_ex_is_mul) begin
                        if (MUL_LAT == 1) begin
                            w_state_next  = MD_ST_DONE;
                            w_load_result = 1'b1;
                            w_result_next = w_mul_prod;
                        end else begin
                            w_state_next = MD_ST_MUL;
                        end
                    end else begin
                        w_state_next = MD_ST_DIV;
                        w_div_start  = 1'b1;
                    end
                end
            end
            MD_ST_MUL: begin
                stall_ex = 1'b1;
                if (r_mcnt == MUL_LAST) begin
                    w_state_next  = MD_ST_DONE;
                    w_load_result = 1'b1;
                    w_result_next = w_mul_prod;
                end
            end
            MD_ST_DIV: begin
                stall_ex = 1'b1;
                if (w_div_done && !w_div_busy) begin
                    w_state_next  = MD_ST_DONE;
                    w_load_result = 1'b1;
                    w_result_next = w_div_res;
                end
            end
            MD_ST_DONE: begin
                w_state_next = MD_ST_IDLE;
            end
            default: begin
                w_state_next = MD_ST_IDLE;
            end
        endcase
        if (flush) begin
            w_state_next  = MD_ST_IDLE;
            w_load_result = 1'b0;
            stall_ex      = 1'b0;
        end
        if (!resetn) begin
            stall_ex = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state        <= MD_ST_IDLE;
            r_op           <= '0;
            r_a            <= '0;
            r_b            <= '0;
            r_mcnt         <= '0;
            r_result       <= '0;
            r_result_valid <= 1'b0;
        end else begin
            r_state        <= w_state_next;
            r_result_valid <= w_load_result;
            if (w_load_result) begin
                r_result <= w_result_next;
            end
            if (w_accept) begin
                r_op   <= ex_op;
                r_a    <= ex_src_a;
                r_b    <= ex_src_b;
                r_mcnt <= '0;
            end else if (r_state == MD_ST_MUL) begin
                r_mcnt <= r_mcnt + MCNT_W'(1);
            end
        end
    end

    assign result       = r_result;
    assign result_valid = r_result_valid;

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Scoreboard bench for muldiv_ctrl: directed ops push expected {HI,LO} and completion cycle; a monitor pops on result_valid.
module tb_muldiv_ctrl;
    import gemini_pkg::*;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        ex_valid = 1'b0;
    logic [2:0]  ex_op = 3'b000;
    logic [31:0] ex_src_a = '0;
    logic [31:0] ex_src_b = '0;
    logic        flush = 1'b0;
    logic        stall_ex;
    logic [63:0] result;
    logic        result_valid;

    muldiv_ctrl #(.MUL_LAT(2)) dut (
        .clk          (clk),
        .resetn       (resetn),
        .ex_valid     (ex_valid),
        .ex_op        (ex_op),
        .ex_src_a     (ex_src_a),
        .ex_src_b     (ex_src_b),
        .flush        (flush),
        .stall_ex     (stall_ex),
        .result       (result),
        .result_valid (result_valid)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [63:0] exp_q[$];
    int          cyc_q[$];
    int          n_pass = 0;
    int          n_total = 0;
    logic [63:0] last_res = '0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_total++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, req, cyc);
    endtask

    // Monitor: every completion pulse must match the oldest outstanding expectation, value and cycle.
    initial begin
        logic [63:0] e;
        int          c;
        forever begin
            @(negedge clk);
            if (resetn && result_valid === 1'b1) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_valid", 64'(result_valid), 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    c = cyc_q.pop_front();
                    chk("result", result, e);
                    chk("latency", 64'(cyc), 64'(c));
                end
            end
        end
    end

    // Drive an op in the current cycle (caller is already at a negedge) and wait for completion.
    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [63:0] expv, input int lat, input bit hold);
        bit seen;
        ex_valid = 1'b1;
        ex_op    = op;
        ex_src_a = a;
        ex_src_b = b;
        #1;
        chk("accept_stall", 64'(stall_ex), 64'd1);
        exp_q.push_back(expv);
        cyc_q.push_back(cyc + lat);
        seen = 1'b0;
        for (int i = 0; i < lat + 4 && !seen; i++) begin
            @(negedge clk);
            if (!hold) ex_valid = 1'b0;
            #1;
            if (result_valid === 1'b1) begin
                seen = 1'b1;
                chk("done_stall", 64'(stall_ex), 64'd0);
                if (hold) begin
                    @(negedge clk);
                    ex_valid = 1'b0;
                    #1;
                    chk("no_relaunch", 64'(stall_ex), 64'd0);
                end
            end else begin
                chk("busy_stall", 64'(stall_ex), 64'd1);
            end
        end
        if (!seen) chk("timeout", 64'(result_valid), 64'd1);
        last_res = expv;
    endtask

    task automatic do_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [63:0] expv, input int lat);
        @(negedge clk);
        run_op(op, a, b, expv, lat, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got cycle %0d, expected under 2000", cyc);
        $fatal(1);
    end

    initial begin
        // Reset with a legal op presented: no stall, cleared outputs.
        ex_valid = 1'b1;
        ex_op    = MD_MULT;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_stall", 64'(stall_ex), 64'd0);
        chk("rst_result", result, 64'd0);
        chk("rst_valid", 64'(result_valid), 64'd0);
        ex_valid = 1'b0;
        resetn   = 1'b1;

        do_op(MD_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFE_00000001, 2);
        do_op(MD_MULT,  32'hFFFFFFFF, 32'h00000002, 64'hFFFFFFFF_FFFFFFFE, 2);
        do_op(MD_MULT,  32'h80000000, 32'h80000000, 64'h40000000_00000000, 2);
        do_op(MD_DIV,   32'hFFFFFFF9, 32'h00000002, 64'hFFFFFFFF_FFFFFFFD, 33);
        do_op(MD_DIVU,  32'h00000007, 32'h00000000, 64'h00000007_FFFFFFFF, 33);
        do_op(MD_DIV,   32'h80000000, 32'hFFFFFFFF, 64'h00000000_80000000, 33);
        do_op(MD_DIVU,  32'd100,      32'd7,        64'h00000002_0000000E, 33);
        do_op(MD_DIV,   32'h00000007, 32'hFFFFFFFE, 64'h00000001_FFFFFFFD, 33);
        do_op(MD_DIV,   32'hFFFFFFFB, 32'h00000000, 64'hFFFFFFFB_FFFFFFFF, 33);
        do_op(MD_DIVU,  32'hFFFFFFFF, 32'h00000001, 64'h00000000_FFFFFFFF, 33);

        // Undefined opcode is treated as NONE.
        @(negedge clk);
        ex_valid = 1'b1;
        ex_op    = 3'b101;
        #1;
        chk("illegal_op_stall", 64'(stall_ex), 64'd0);
        @(negedge clk);
        ex_valid = 1'b0;
        #1;
        chk("illegal_op_idle", 64'(stall_ex), 64'd0);

        // Flush a DIV at T+10, then accept a MULT the following cycle.
        @(negedge clk);
        ex_valid = 1'b1;
        ex_op    = MD_DIV;
        ex_src_a = 32'd1000;
        ex_src_b = 32'd3;
        #1;
        chk("flush_accept_stall", 64'(stall_ex), 64'd1);
        @(negedge clk);
        ex_valid = 1'b0;
        repeat (9) @(negedge clk);
        flush = 1'b1;
        #1;
        chk("flush_stall", 64'(stall_ex), 64'd0);
        @(negedge clk);
        flush = 1'b0;
        #1;
        chk("post_flush_stall", 64'(stall_ex), 64'd0);
        chk("post_flush_result", result, last_res);
        chk("post_flush_valid", 64'(result_valid), 64'd0);
        run_op(MD_MULT, 32'd3, 32'hFFFFFFFC, 64'hFFFFFFFF_FFFFFFF4, 2, 1'b0);
        repeat (40) @(negedge clk);
        #1;
        chk("flush_result_held", result, last_res);

        // Reset in the middle of a DIV abandons it.
        @(negedge clk);
        ex_valid = 1'b1;
        ex_op    = MD_DIV;
        ex_src_a = 32'd50;
        ex_src_b = 32'd5;
        #1;
        chk("rst_div_accept", 64'(stall_ex), 64'd1);
        @(negedge clk);
        ex_valid = 1'b0;
        repeat (5) @(negedge clk);
        resetn   = 1'b0;
        ex_valid = 1'b1;
        exp_q.delete();
        cyc_q.delete();
        #1;
        chk("rst_mid_stall", 64'(stall_ex), 64'd0);
        @(negedge clk);
        #1;
        chk("rst_mid_result", result, 64'd0);
        chk("rst_mid_valid", 64'(result_valid), 64'd0);
        chk("rst_mid_stall2", 64'(stall_ex), 64'd0);
        ex_valid = 1'b0;
        resetn   = 1'b1;
        repeat (40) @(negedge clk);
        #1;
        chk("rst_no_stale", result, 64'd0);

        // ex_valid held high through DONE must not relaunch.
        @(negedge clk);
        run_op(MD_MULTU, 32'd5, 32'd6, 64'h00000000_0000001E, 2, 1'b1);
        repeat (5) @(negedge clk);
        chk("queue_empty", 64'(exp_q.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
